vram_rect_fill: RTL and testbench



---
 rtl/vga_pkg.sv | 19 +
 rtl/vram_addr_gen.sv | 85 ++++++++
 rtl/vram_rect_fill.sv | 133 +++++++++++++
 tb/tb_vram_rect_fill.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA frame-buffer constants, pixel type and fill FSM states
package vga_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int PIX_W  = 12;

    // {B[11:8], G[7:4], R[3:0]}
    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/vram_addr_gen.sv
// rtl/vram_addr_gen.sv - clipped rectangle walker producing linear VRAM addresses without a multiplier
module vram_addr_gen
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic [9:0]        i_w,
    input  logic [8:0]        i_h,
    output logic              o_empty,
    output logic              o_last,
    output logic [ADDR_W-1:0] o_addr
);

    logic [10:0]       r_col;
    logic [9:0]        r_row;
    logic [10:0]       r_x_end;
    logic [9:0]        r_y_end;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_addr;

    // Sums are one bit wider than the operands so a large width/height cannot wrap.
    logic [10:0]       w_x_sum;
    logic [9:0]        w_y_sum;
    logic [10:0]       w_x_end;
    logic [9:0]        w_y_end;
    logic [ADDR_W-1:0] w_y_ext;
    logic [ADDR_W-1:0] w_x_ext;
    logic [ADDR_W-1:0] w_row_base0;
    logic [10:0]       w_col_inc;
    logic [9:0]        w_row_inc;
    logic              w_col_more;
    logic              w_row_more;

    assign w_x_sum     = {1'b0, i_x} + {1'b0, i_w};
    assign w_y_sum     = {1'b0, i_y} + {1'b0, i_h};
    assign w_x_end     = (w_x_sum > 11'(H_RES)) ? 11'(H_RES) : w_x_sum;
    assign w_y_end     = (w_y_sum > 10'(V_RES)) ? 10'(V_RES) : w_y_sum;
    assign o_empty     = (i_x >= 10'(H_RES)) || (i_y >= 9'(V_RES)) || (i_w == '0) || (i_h == '0);

    // y*640 as (y<<9)+(y<<7)
    assign w_y_ext     = {10'd0, i_y};
    assign w_x_ext     = {9'd0, i_x};
    assign w_row_base0 = (w_y_ext << 9) + (w_y_ext << 7);

    assign w_col_inc   = r_col + 11'd1;
    assign w_row_inc   = r_row + 10'd1;
    assign w_col_more  = (w_col_inc < r_x_end);
    assign w_row_more  = (w_row_inc < r_y_end);
    assign o_last      = !w_col_more && !w_row_more;
    assign o_addr      = r_addr;

    // Load the first pixel of the clipped rectangle, then advance one pixel per accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_x_end    <= '0;
            r_y_end    <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else if (i_load) begin
            r_col      <= {1'b0, i_x};
            r_row      <= {1'b0, i_y};
            r_x_end    <= w_x_end;
            r_y_end    <= w_y_end;
            r_row_base <= w_row_base0;
            r_addr     <= w_row_base0 + w_x_ext;
        end else if (i_step) begin
            if (w_col_more) begin
                r_col  <= w_col_inc;
                r_addr <= r_addr + 1'b1;
            end else if (w_row_more) begin
                r_col      <= {1'b0, i_x};
                r_row      <= w_row_inc;
                r_row_base <= r_row_base + ADDR_W'(H_RES);
                r_addr     <= r_row_base + ADDR_W'(H_RES) + w_x_ext;
            end
        end
    end

endmodule

// File: rtl/vram_rect_fill.sv
// rtl/vram_rect_fill.sv - rectangle-fill command engine driving the single-pixel VRAM write port
module vram_rect_fill
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [PIX_W-1:0]  cmd_color,
    output logic              vram_wen,
    output logic [ADDR_W-1:0] vram_waddr,
    output logic [PIX_W-1:0]  vram_wdata,
    input  logic              vram_stall,
    output logic              busy,
    output logic              done
);

    fill_state_t r_state;
    fill_state_t w_next;

    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [9:0]  r_w;
    logic [8:0]  r_h;
    pixel_t      r_color;
    logic        r_wen;
    pixel_t      r_wdata;

    logic        w_accept;
    logic        w_take;
    logic        w_load;
    logic        w_empty;
    logic        w_last;
    logic [ADDR_W-1:0] w_addr;

    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    assign w_take     = (r_state == ST_RUN) && r_wen && !vram_stall;
    assign w_load     = (r_state == ST_SETUP) && !w_empty;

    assign vram_wen   = r_wen;
    assign vram_wdata = r_wdata;
    assign vram_waddr = w_addr;

    vram_addr_gen u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_step  (w_take),
        .i_x     (r_x),
        .i_y     (r_y),
        .i_w     (r_w),
        .i_h     (r_h),
        .o_empty (w_empty),
        .o_last  (w_last),
        .o_addr  (w_addr)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded handshake/status outputs
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_next = w_empty ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_take && w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Capture the command; later inputs are ignored until the engine is idle again
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
        end else if (w_accept) begin
            r_x     <= cmd_x;
            r_y     <= cmd_y;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= cmd_color;
        end
    end

    // Write request: raised with the first pixel, held through stalls, dropped after the last pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_wdata <= '0;
        end else if (w_load) begin
            r_wen   <= 1'b1;
            r_wdata <= r_color;
        end else if (w_take && w_last) begin
            r_wen   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_rect_fill.sv
// tb/tb_vram_rect_fill.sv - scoreboard bench for vram_rect_fill
module tb_vram_rect_fill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0;
    logic [8:0]  cmd_y = '0;
    logic [9:0]  cmd_w = '0;
    logic [8:0]  cmd_h = '0;
    logic [11:0] cmd_color = '0;
    logic        vram_wen;
    logic [18:0] vram_waddr;
    logic [11:0] vram_wdata;
    logic        vram_stall = 1'b0;
    logic        busy;
    logic        done;

    typedef struct {
        bit          is_done;
        logic [18:0] addr;
        logic [11:0] data;
        int          off;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   done_cyc = 0;
    bit   ignore_writes = 1'b0;

    vram_rect_fill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_color  (cmd_color),
        .vram_wen   (vram_wen),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_stall (vram_stall),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every write and done pulse against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (vram_wen) begin
                checks++;
                if (vram_waddr >= 19'd307200) begin
                    errors++;
                    $display("FAIL addr_range: addr %0d, required < 307200", vram_waddr);
                end
                if (!ignore_writes) begin
                    checks++;
                    if (q.size() == 0 || q[0].is_done) begin
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data %h at cycle %0d, required no write", vram_waddr, vram_wdata, cyc);
                    end else begin
                        if (vram_waddr != q[0].addr || vram_wdata != q[0].data ||
                            (!vram_stall && (cyc - acc_cyc) != q[0].off)) begin
                            errors++;
                            $display("FAIL write: addr %0d data %h offset %0d stall %0b, required addr %0d data %h offset %0d",
                                     vram_waddr, vram_wdata, cyc - acc_cyc, vram_stall, q[0].addr, q[0].data, q[0].off);
                        end
                        if (!vram_stall) void'(q.pop_front());
                    end
                end
            end
            if (done) begin
                checks++;
                done_cyc = cyc;
                if (q.size() == 0 || !q[0].is_done) begin
                    errors++;
                    $display("FAIL unexpected_done: done at cycle %0d, required pending writes or nothing", cyc);
                end else begin
                    if ((cyc - acc_cyc) != q[0].off) begin
                        errors++;
                        $display("FAIL done_latency: offset %0d, required %0d", cyc - acc_cyc, q[0].off);
                    end
                    void'(q.pop_front());
                end
            end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
        end
    end

    task automatic exp_wr(input int addr, input int data, input int off);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = 19'(addr);
        e.data    = 12'(data);
        e.off     = off;
        q.push_back(e);
    endtask

    task automatic exp_done(input int off);
        exp_t e;
        e.is_done = 1'b1;
        e.addr    = '0;
        e.data    = '0;
        e.off     = off;
        q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic send(input int x, input int y, input int w, input int h, input int color, input bit keep);
        int n;
        bit ok;
        cmd_x     = 10'(x);
        cmd_y     = 9'(y);
        cmd_w     = 10'(w);
        cmd_h     = 9'(h);
        cmd_color = 12'(color);
        cmd_valid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (n < 300) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cmd_ready stayed 0, required 1");
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!keep) cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expected events left, required 0", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", int'(cmd_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_wen", int'(vram_wen), 0);
        check("reset_waddr", int'(vram_waddr), 0);
        check("reset_wdata", int'(vram_wdata), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 2x2 at origin
        exp_wr(0, 12'h00F, 2);
        exp_wr(1, 12'h00F, 3);
        exp_wr(640, 12'h00F, 4);
        exp_wr(641, 12'h00F, 5);
        exp_done(6);
        send(0, 0, 2, 2, 12'h00F, 1'b0);
        drain();
        check("t1_cmd_ready", int'(cmd_ready), 1);

        // 2: clipped at bottom-right corner
        exp_wr(307198, 12'hF00, 2);
        exp_wr(307199, 12'hF00, 3);
        exp_done(4);
        send(638, 479, 4, 3, 12'hF00, 1'b0);
        drain();

        // 3: empty rectangles
        exp_done(2);
        send(640, 10, 5, 5, 12'h0F0, 1'b0);
        drain();
        exp_done(2);
        send(5, 5, 0, 3, 12'h0F0, 1'b0);
        drain();

        // 4: stall during second write
        exp_wr(10, 12'h5A5, 2);
        exp_wr(11, 12'h5A5, 6);
        exp_wr(12, 12'h5A5, 7);
        exp_done(8);
        send(10, 0, 3, 1, 12'h5A5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        vram_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vram_stall = 1'b0;
        drain();

        // 5: asynchronous reset in the middle of a large fill
        ignore_writes = 1'b1;
        send(0, 0, 100, 100, 12'h0F0, 1'b0);
        repeat (50) @(posedge clk);
        check("t5_busy_before_reset", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_wen_async", int'(vram_wen), 0);
        check("t5_busy_async", int'(busy), 0);
        check("t5_ready_async", int'(cmd_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ignore_writes = 1'b0;
        exp_wr(641, 12'hABC, 2);
        exp_done(3);
        send(1, 1, 1, 1, 12'hABC, 1'b0);
        drain();

        // 6: back-to-back commands with cmd_valid held high
        exp_wr(1922, 12'h123, 2);
        exp_wr(1923, 12'h123, 3);
        exp_done(4);
        send(2, 3, 2, 1, 12'h123, 1'b1);
        check("t6_ready_low_during_first", int'(cmd_ready), 0);
        exp_wr(0, 12'h456, 2);
        exp_wr(640, 12'h456, 3);
        exp_done(4);
        send(0, 0, 1, 2, 12'h456, 1'b0);
        check("t6_accept_after_done", acc_cyc - done_cyc, 1);
        drain();
        check("final_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
